// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module  : pipe_pkg
// Brief   : Shared multiply/divide unit types and constants.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    localparam int DIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/pipe_div_core.sv
//------------------------------------------------------------------------------
// Module  : pipe_div_core
// Brief   : 32-iteration restoring divider with sign correction in a FIX cycle.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_div_core
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_q,
    output logic [31:0] o_r
);

    localparam logic [4:0] c_last_iter = 5'(DIV_ITERS - 1);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dvs_zero;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_fits;

    always_comb begin
        w_a_mag   = (i_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
        w_b_mag   = (i_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
        // r_quo doubles as the dividend shift register; its MSB feeds the remainder
        w_partial = {r_rem, r_quo[31]};
        w_diff    = w_partial - {1'b0, r_dvs};
        w_fits    = (w_partial >= {1'b0, r_dvs});
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == c_last_iter) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_cnt      <= 5'd0;
            r_quo      <= 32'd0;
            r_rem      <= 32'd0;
            r_dvs      <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dvs_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt      <= 5'd0;
                        r_quo      <= w_a_mag;
                        r_rem      <= 32'd0;
                        r_dvs      <= w_b_mag;
                        r_neg_q    <= i_signed & (i_a[31] ^ i_b[31]);
                        r_neg_r    <= i_signed & i_a[31];
                        r_dvs_zero <= (i_b == 32'd0);
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_quo <= {r_quo[30:0], w_fits};
                    r_rem <= w_fits ? w_diff[31:0] : w_partial[31:0];
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    // Zero divisor leaves |dividend| in r_rem, so only the quotient needs forcing
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_FIX);
    assign o_q    = r_dvs_zero ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quo) : r_quo);
    assign o_r    = r_neg_r ? (32'd0 - r_rem) : r_rem;

endmodule

`default_nettype wire

// File: rtl/pipe_exe_mdu.sv
//------------------------------------------------------------------------------
// Module  : pipe_exe_mdu
// Brief   : EX-stage multiply/divide unit owning the HI/LO registers.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_exe_mdu
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        emult,
    input  logic        emultu,
    input  logic        ediv,
    input  logic        edivu,
    input  logic        emthi,
    input  logic        emtlo,
    input  logic        emfhi,
    input  logic        emflo,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out,
    output logic        busy,
    output logic        stall
);

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_any_op;
    logic               w_accept;
    logic               w_div_start;
    logic               w_div_busy;
    logic               w_div_done;
    logic [31:0]        w_div_q;
    logic [31:0]        w_div_r;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;

    assign w_any_op    = emult | emultu | ediv | edivu | emthi | emtlo;
    assign stall       = w_div_busy & (w_any_op | emfhi | emflo) & ~clrn;
    assign w_accept    = ~stall;
    assign w_div_start = (ediv | edivu) & w_accept;

    assign w_prod_s = $signed(ea) * $signed(eb);
    assign w_prod_u = {32'd0, ea} * {32'd0, eb};

    pipe_div_core u_div (
        .clk      (clk),
        .clrn     (clrn),
        .i_start  (w_div_start),
        .i_signed (ediv),
        .i_a      (ea),
        .i_b      (eb),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_q      (w_div_q),
        .o_r      (w_div_r)
    );

    // FIX cycle stalls every other op, so the divide write never collides
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_div_done) begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
        end else if (w_accept) begin
            if (emult) begin
                {r_hi, r_lo} <= w_prod_s;
            end else if (emultu) begin
                {r_hi, r_lo} <= w_prod_u;
            end else begin
                if (emthi) r_hi <= ea;
                if (emtlo) r_lo <= ea;
            end
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = w_div_busy;
    assign mdu_out = emfhi ? r_hi : r_lo;

endmodule

`default_nettype wire
